// File: rtl/key_press_decoder.sv
// Turns a debounced key level into press / short / long / repeat pulses
// plus a held level for the time-setting logic.
module key_press_decoder #(
    parameter logic        PRESS_LEVEL = 1'b0,
    parameter logic [23:0] LONG_CNT    = 24'd12_000_000,
    parameter logic [23:0] REPEAT_CNT  = 24'd3_000_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_key,
    output logic o_press,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam logic [1:0] S_ARM  = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_LONG = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        press_q, press_d;
    logic        short_q, short_d;
    logic        long_q, long_d;
    logic        repeat_q, repeat_d;
    logic        held_q, held_d;

    logic        pressed;
    logic [23:0] cnt_inc;

    assign pressed = (i_key == PRESS_LEVEL);
    assign cnt_inc = cnt_q + 24'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        held_d   = held_q;
        case (state_q)
            S_ARM: begin
                if (!pressed) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (pressed) begin
                    state_d = S_HOLD;
                    press_d = 1'b1;
                    held_d  = 1'b1;
                    cnt_d   = 24'd1;
                end
            end
            S_HOLD: begin
                // release is tested first so it beats a coinciding threshold
                if (!pressed) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                    held_d  = 1'b0;
                    cnt_d   = 24'd0;
                end else if (cnt_inc == LONG_CNT) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                    cnt_d   = 24'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                if (!pressed) begin
                    state_d = S_IDLE;
                    held_d  = 1'b0;
                    cnt_d   = 24'd0;
                end else if (cnt_q == REPEAT_CNT) begin
                    repeat_d = 1'b1;
                    cnt_d    = 24'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_ARM;
            cnt_q    <= 24'd0;
            press_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
        end
    end

    assign o_press  = press_q;
    assign o_short  = short_q;
    assign o_long   = long_q;
    assign o_repeat = repeat_q;
    assign o_held   = held_q;

endmodule

// File: tb/tb_key_press_decoder.sv
// Self-checking bench for key_press_decoder with short thresholds
// (long at 8, repeat every 4).
module tb_key_press_decoder;

    localparam int L = 8;
    localparam int R = 4;

    logic clk;
    logic rst_n;
    logic i_key;
    logic o_press, o_short, o_long, o_repeat, o_held;

    key_press_decoder #(
        .PRESS_LEVEL(1'b0),
        .LONG_CNT(24'd8),
        .REPEAT_CNT(24'd4)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_key(i_key),
        .o_press(o_press),
        .o_short(o_short),
        .o_long(o_long),
        .o_repeat(o_repeat),
        .o_held(o_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       key;
        logic [4:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [4:0] sb[$];
    logic [4:0] obs;

    // reference model state: counts edges since the press was sampled
    logic m_armed, m_held, m_long;
    int   m_k;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_held  = 1'b0;
        m_long  = 1'b0;
        m_k     = 0;
    endtask

    task automatic model(input logic key, output logic [4:0] e);
        logic p;
        p = (key == 1'b0);
        e = 5'b0;
        if (!m_armed) begin
            if (!p) m_armed = 1'b1;
        end else if (!m_held) begin
            if (p) begin
                e[4]   = 1'b1;
                m_held = 1'b1;
                m_long = 1'b0;
                m_k    = 0;
            end
        end else if (!p) begin
            m_held = 1'b0;
            e[3]   = !m_long;
        end else begin
            m_k++;
            if (m_k == L - 1) begin
                e[2]   = 1'b1;
                m_long = 1'b1;
            end else if (m_long && ((m_k - (L - 1)) % R == 0)) begin
                e[1] = 1'b1;
            end
        end
        e[0] = m_held;
    endtask

    function automatic logic [4:0] dut_out();
        return {o_press, o_short, o_long, o_repeat, o_held};
    endfunction

    task automatic step(input logic key);
        logic [4:0] e;
        logic [4:0] want;
        @(negedge clk);
        i_key = key;
        @(posedge clk);
        model(key, e);
        sb.push_back(e);
        #1;
        obs  = dut_out();
        want = sb.pop_front();
        check("cycle", int'(obs), int'(want));
    endtask

    initial begin
        vec_t vecs[$];
        int   long_at;
        int   reps[$];
        int   shorts;
        int   evs;
        logic pend;
        logic lvl;
        int   run;
        int   cyc;

        rst_n = 1'b0;
        i_key = 1'b0;
        obs   = 5'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", int'(dut_out()), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // arming and short click: {key, press short long repeat held}
        for (int i = 0; i < 20; i++) vecs.push_back('{key: 1'b0, exp: 5'b00000});
        vecs.push_back('{key: 1'b1, exp: 5'b00000});
        vecs.push_back('{key: 1'b1, exp: 5'b00000});
        vecs.push_back('{key: 1'b0, exp: 5'b10001});
        vecs.push_back('{key: 1'b1, exp: 5'b01000});
        vecs.push_back('{key: 1'b1, exp: 5'b00000});
        vecs.push_back('{key: 1'b0, exp: 5'b10001});
        for (int i = 0; i < 4; i++) vecs.push_back('{key: 1'b0, exp: 5'b00001});
        vecs.push_back('{key: 1'b1, exp: 5'b01000});
        vecs.push_back('{key: 1'b1, exp: 5'b00000});
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].key);
            check($sformatf("vec%0d", i), int'(obs), int'(vecs[i].exp));
        end

        // long press with repeat, 20 pressed samples
        long_at = -1;
        shorts  = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (obs[2]) long_at = i;
            if (obs[1]) reps.push_back(i);
            if (obs[3]) shorts++;
        end
        check("long_at", long_at, 7);
        check("rep_cnt", reps.size(), 3);
        if (reps.size() >= 2) begin
            check("rep0_at", reps[0], 11);
            check("rep1_at", reps[1], 15);
        end
        step(1'b1);
        check("long_release", int'(obs), 0);
        check("long_no_short", shorts, 0);

        // release exactly where o_long would fire
        step(1'b1);
        evs = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            if (obs[2]) evs++;
        end
        step(1'b1);
        check("long_collide", int'(obs), 5'b01000);
        check("long_collide_none", evs, 0);

        // release exactly where the first o_repeat would fire
        step(1'b1);
        evs = 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b0);
            if (obs[1]) evs++;
        end
        step(1'b1);
        check("rep_collide", int'(obs), 0);
        check("rep_collide_none", evs, 0);

        // asynchronous reset while in LONG
        step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", int'(dut_out()), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        evs = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            if (obs[4]) evs++;
        end
        check("held_after_reset", evs, 0);
        step(1'b1);
        step(1'b0);
        check("rearm_press", int'(obs), 5'b10001);
        step(1'b1);

        // random press/release traffic
        step(1'b1);
        pend = 1'b0;
        lvl  = 1'b1;
        cyc  = 0;
        while (cyc < 10000) begin
            lvl = ~lvl;
            run = $urandom_range(1, 16);
            for (int i = 0; i < run; i++) begin
                step(lvl);
                cyc++;
                check("onehot0", int'($onehot0(obs[4:1])), 1);
                if (obs[4]) begin
                    check("press_pending", int'(pend), 0);
                    pend = 1'b1;
                end
                if (obs[3] || obs[2]) begin
                    check("resolve_pending", int'(pend), 1);
                    pend = 1'b0;
                end
            end
        end
        step(1'b1);
        if (obs[3] || obs[2]) pend = 1'b0;
        check("final_pending", int'(pend), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
